// File: rtl/axi_arbiter.sv
// Two-requester (IFU read, LSU read/write) arbiter onto one single-beat AXI4 master port.
// Define AXI_ARB_RR_EN for IFU/LSU round-robin; otherwise fixed LSU write > LSU read > IFU read.
module axi_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clock,
  input  logic                reset,
  // IFU read
  input  logic                ifu_arvalid,
  output logic                ifu_arready,
  input  logic [ADDR_W-1:0]   ifu_araddr,
  output logic                ifu_rvalid,
  input  logic                ifu_rready,
  output logic [DATA_W-1:0]   ifu_rdata,
  output logic [1:0]          ifu_rresp,
  // LSU read
  input  logic                lsu_arvalid,
  output logic                lsu_arready,
  input  logic [ADDR_W-1:0]   lsu_araddr,
  input  logic [2:0]          lsu_arsize,
  output logic                lsu_rvalid,
  input  logic                lsu_rready,
  output logic [DATA_W-1:0]   lsu_rdata,
  output logic [1:0]          lsu_rresp,
  // LSU write
  input  logic                lsu_awvalid,
  output logic                lsu_awready,
  input  logic [ADDR_W-1:0]   lsu_awaddr,
  input  logic [2:0]          lsu_awsize,
  input  logic                lsu_wvalid,
  output logic                lsu_wready,
  input  logic [DATA_W-1:0]   lsu_wdata,
  input  logic [DATA_W/8-1:0] lsu_wstrb,
  output logic                lsu_bvalid,
  input  logic                lsu_bready,
  output logic [1:0]          lsu_bresp,
  // Downstream master port
  input  logic                io_master_awready,
  output logic                io_master_awvalid,
  output logic [ADDR_W-1:0]   io_master_awaddr,
  output logic [3:0]          io_master_awid,
  output logic [7:0]          io_master_awlen,
  output logic [2:0]          io_master_awsize,
  output logic [1:0]          io_master_awburst,
  input  logic                io_master_wready,
  output logic                io_master_wvalid,
  output logic [DATA_W-1:0]   io_master_wdata,
  output logic [DATA_W/8-1:0] io_master_wstrb,
  output logic                io_master_wlast,
  output logic                io_master_bready,
  input  logic                io_master_bvalid,
  input  logic [1:0]          io_master_bresp,
  input  logic [3:0]          io_master_bid,
  input  logic                io_master_arready,
  output logic                io_master_arvalid,
  output logic [ADDR_W-1:0]   io_master_araddr,
  output logic [3:0]          io_master_arid,
  output logic [7:0]          io_master_arlen,
  output logic [2:0]          io_master_arsize,
  output logic [1:0]          io_master_arburst,
  output logic                io_master_rready,
  input  logic                io_master_rvalid,
  input  logic [1:0]          io_master_rresp,
  input  logic [DATA_W-1:0]   io_master_rdata,
  input  logic                io_master_rlast,
  input  logic [3:0]          io_master_rid,
  // Sticky debug flag: a response arrived that matched no active transaction
  output logic                spurious_resp
);

  typedef enum logic [1:0] {IDLE, IFU_RD, LSU_RD, LSU_WR} state_t;

  localparam logic [3:0] IFU_ID = 4'd0;
  localparam logic [3:0] LSU_ID = 4'd1;

  state_t state;
  state_t grant;
  logic   addr_done;
  logic   aw_done;
  logic   w_done;
  logic   lsu_first;
  logic   r_match;
  logic   b_match;
  logic   ar_hs;
  logic   aw_hs;
  logic   w_hs;
  logic   r_fire;
  logic   b_fire;
  logic   stray;
  logic   unused_rlast;

  // Single-beat reads never need rlast.
  assign unused_rlast = io_master_rlast;

`ifdef AXI_ARB_RR_EN
  logic last_owner;  // 1: LSU held the bus last, 0: IFU did

  // A tie goes to whoever did not own the bus last.
  assign lsu_first = (lsu_awvalid | lsu_arvalid) & (~ifu_arvalid | ~last_owner);
`else
  assign lsu_first = lsu_awvalid | lsu_arvalid;
`endif

  always_comb begin
    grant = IDLE;
    if (lsu_first)        grant = lsu_awvalid ? LSU_WR : LSU_RD;
    else if (ifu_arvalid) grant = IFU_RD;
  end

  // A response only belongs to the transaction once its request phase is complete.
  assign r_match = ((state == IFU_RD) || (state == LSU_RD)) && addr_done &&
                   (io_master_rid == ((state == LSU_RD) ? LSU_ID : IFU_ID));
  assign b_match = (state == LSU_WR) && aw_done && w_done && (io_master_bid == LSU_ID);

  assign ar_hs  = io_master_arvalid & io_master_arready;
  assign aw_hs  = io_master_awvalid & io_master_awready;
  assign w_hs   = io_master_wvalid & io_master_wready;
  assign r_fire = io_master_rvalid & io_master_rready;
  assign b_fire = io_master_bvalid & io_master_bready;
  assign stray  = (r_fire & ~r_match) | (b_fire & ~b_match);

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      addr_done     <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      spurious_resp <= 1'b0;
`ifdef AXI_ARB_RR_EN
      last_owner    <= 1'b1;
`endif
    end else begin
      if (stray) spurious_resp <= 1'b1;
      case (state)
        IDLE: state <= grant;
        IFU_RD, LSU_RD: begin
          if (ar_hs) addr_done <= 1'b1;
          if (r_match && r_fire) begin
            state     <= IDLE;
            addr_done <= 1'b0;
`ifdef AXI_ARB_RR_EN
            last_owner <= (state == LSU_RD);
`endif
          end
        end
        LSU_WR: begin
          if (aw_hs) aw_done <= 1'b1;
          if (w_hs)  w_done  <= 1'b1;
          if (b_match && b_fire) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
`ifdef AXI_ARB_RR_EN
            last_owner <= 1'b1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Owner channels pass straight through; everything else is held off.
  always_comb begin
    io_master_arvalid = 1'b0;
    io_master_araddr  = ifu_araddr;
    io_master_arid    = IFU_ID;
    io_master_arsize  = 3'b010;
    io_master_arlen   = 8'd0;
    io_master_arburst = 2'b01;
    ifu_arready       = 1'b0;
    lsu_arready       = 1'b0;
    if (state == IFU_RD) begin
      io_master_arvalid = ifu_arvalid & ~addr_done;
      ifu_arready       = io_master_arready & ~addr_done;
    end else if (state == LSU_RD) begin
      io_master_arvalid = lsu_arvalid & ~addr_done;
      io_master_araddr  = lsu_araddr;
      io_master_arid    = LSU_ID;
      io_master_arsize  = lsu_arsize;
      lsu_arready       = io_master_arready & ~addr_done;
    end

    ifu_rvalid = r_match && (state == IFU_RD) && io_master_rvalid;
    lsu_rvalid = r_match && (state == LSU_RD) && io_master_rvalid;
    ifu_rdata  = io_master_rdata;
    lsu_rdata  = io_master_rdata;
    ifu_rresp  = io_master_rresp;
    lsu_rresp  = io_master_rresp;
    if (r_match) io_master_rready = (state == LSU_RD) ? lsu_rready : ifu_rready;
    else         io_master_rready = ~reset;

    io_master_awvalid = (state == LSU_WR) & lsu_awvalid & ~aw_done;
    io_master_awaddr  = lsu_awaddr;
    io_master_awid    = LSU_ID;
    io_master_awlen   = 8'd0;
    io_master_awsize  = lsu_awsize;
    io_master_awburst = 2'b01;
    lsu_awready       = (state == LSU_WR) & io_master_awready & ~aw_done;

    io_master_wvalid = (state == LSU_WR) & lsu_wvalid & ~w_done;
    io_master_wdata  = lsu_wdata;
    io_master_wstrb  = lsu_wstrb;
    io_master_wlast  = io_master_wvalid;
    lsu_wready       = (state == LSU_WR) & io_master_wready & ~w_done;

    lsu_bvalid       = b_match & io_master_bvalid;
    lsu_bresp        = io_master_bresp;
    io_master_bready = b_match ? lsu_bready : ~reset;
  end

endmodule

// File: doc/axi_arbiter.md
# axi_arbiter

Two-requester, single-port AXI4 arbiter that shares the core's one external AXI master port between the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read and write). It accepts one single-beat transaction at a time and grants the bus to one requester. It holds the grant until the transaction's response completes, then returns to arbitration. It sits between the IFU/LSU front-ends and the `io_master_*` SoC port.

## Interface
Parameters:
- `ADDR_W`, 32, address width on all channels.
- `DATA_W`, 32, data width; `DATA_W/8` strobe bits.

Ports (clock and reset first):
- `clock`  in  1  system clock.
- `reset`  in  1  synchronous, active-high.
- `ifu_arvalid`/`ifu_arready`  in/out  1  IFU read address handshake.
- `ifu_araddr`  in  `ADDR_W`  IFU fetch address; `arsize` is fixed 3'b010.
- `ifu_rvalid`/`ifu_rready`  out/in  1  IFU read data handshake.
- `ifu_rdata`, `ifu_rresp`  out  `DATA_W`, 2  IFU read data and response.
- `lsu_arvalid`/`lsu_arready`  in/out  1  LSU read address handshake.
- `lsu_araddr`, `lsu_arsize`  in  `ADDR_W`, 3  LSU read address and size.
- `lsu_rvalid`/`lsu_rready`  out/in  1  LSU read data handshake.
- `lsu_rdata`, `lsu_rresp`  out  `DATA_W`, 2  LSU read data and response.
- `lsu_awvalid`/`lsu_awready`  in/out  1  LSU write address handshake.
- `lsu_awaddr`, `lsu_awsize`  in  `ADDR_W`, 3  LSU write address and size.
- `lsu_wvalid`/`lsu_wready`  in/out  1  LSU write data handshake.
- `lsu_wdata`, `lsu_wstrb`  in  `DATA_W`, `DATA_W/8`  LSU write data and strobe.
- `lsu_bvalid`/`lsu_bready`  out/in  1  LSU write response handshake.
- `lsu_bresp`  out  2  LSU write response.
- `io_master_aw*`, `io_master_w*`, `io_master_b*`, `io_master_ar*`, `io_master_r*`  mixed  AXI4 widths  downstream master port, same signal set and directions as the core top-level `io_master_*` bundle.

## Operation
- States:
  - `IDLE`: no grant.
  - `IFU_RD`: IFU read granted.
  - `LSU_RD`: LSU read granted.
  - `LSU_WR`: LSU write granted.
- Arbitration happens only in `IDLE`. A requester is pending when its `arvalid` is high, or, for an LSU write, when `lsu_awvalid` is high.
- Fixed priority (default): LSU write > LSU read > IFU read.
- In a granted state, the owner's channels pass combinationally to/from `io_master_*`. All non-owner ready/valid outputs are driven 0.
- Fixed downstream fields:
  - `arlen` = `awlen` = 0; `arburst` = `awburst` = 2'b01; `wlast` = `io_master_wvalid`.
  - `arid` = 0 for IFU, 1 for LSU; `awid` = 1.
  - `arsize` = 3'b010 for IFU, `lsu_arsize` for LSU.
- Read grant: the AR handshake sets an internal `addr_done` flag, and `io_master_arvalid` is 0 after that. The state returns to `IDLE` on the R handshake (rvalid & rready). `rlast` is not required.
- Write grant: AW and W are independent and may complete in either order or in the same cycle. Flags `aw_done` and `w_done` gate their valids off after each handshake. The state returns to `IDLE` on the B handshake. A B response is ignored unless both `aw_done` and `w_done` are set.
- `rresp` and `bresp` are forwarded unchanged. Error responses do not alter sequencing.
- Any `rvalid`/`bvalid` arriving in `IDLE`, or not matching the active transaction, is accepted (`rready`/`bready` = 1 in `IDLE`) and dropped. A sticky debug register `spurious_resp` is set in that case.

## Timing
- Reset: state `IDLE` and all done flags 0. Every requester ready/valid output and every `io_master_*` valid/ready output is 0.
- Grant latency: a request seen in cycle N makes `io_master_arvalid`/`awvalid` high in cycle N+1.
- Release: the response handshake in cycle M puts the state in `IDLE` at M+1. The next grant is therefore visible at M+2, so there is one dead cycle between transactions.
- Zero-wait slave: a read occupies 3 cycles including `IDLE`; a write occupies 3–4 cycles.
- A requester that drops valid before its handshake while granted is a protocol violation; the arbiter holds the grant regardless.
- Reset mid-transaction aborts immediately. No response is owed upstream, and a late downstream response is dropped as spurious.

## Configuration
- `AXI_ARB_RR_EN` defined:
  - Round-robin between IFU and LSU. A 1-bit `last_owner` register is updated on each release.
  - After an IFU grant, the LSU wins a tie; after an LSU grant, the IFU wins a tie.
  - Within the LSU, write still beats read.
- Undefined: fixed priority as in Operation, and the `last_owner` register is absent.

## Test plan
- Single IFU fetch, `araddr`=0x8000_0000, slave returns 0x0000_0413 after 2 cycles -> `ifu_rdata`=0x0000_0413, `io_master_arid`=0, `arsize`=3'b010, back in `IDLE` one cycle after R.
- Simultaneous IFU read 0x8000_0004 and LSU write 0x8000_1000 / 0xDEAD_BEEF, `wstrb`=4'hF -> write granted first (default build); IFU `arvalid` downstream appears two cycles after B.
- Slave accepts W two cycles before AW -> `wvalid` drops after its handshake, the write completes once, and `lsu_bvalid` pulses for exactly one cycle.
- LSU byte read, `lsu_arsize`=0, slave returns `rresp`=2'b10 -> `lsu_rresp`=2'b10, `io_master_arid`=1, no hang.
- `AXI_ARB_RR_EN` build with both requesters continuously valid -> grants strictly alternate IFU, LSU, IFU, LSU over 8 transactions.
- `reset` asserted during `LSU_RD` after the AR handshake -> all valids 0 next cycle; the late `rvalid` is accepted in `IDLE` and sets `spurious_resp`.
